// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the scoreboard game/shot clock logic.
package scoreboard_pkg;

    // FSM state codes; these values are visible on the state port
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_BREAK = 3'd3,
        ST_FINAL = 3'd4
    } gc_state_t;

    // Width of every seconds counter (covers 0..99)
    localparam int SEC_W = 7;

    // Digit code that the 7-segment driver renders as an unlit digit
    localparam logic [3:0] BLANK = 4'hF;

    // Split 0..99 into {tens, units} BCD digits
    function automatic logic [7:0] bin2bcd(input logic [SEC_W-1:0] sec);
        return {4'(sec / SEC_W'(10)), 4'(sec % SEC_W'(10))};
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: one-cycle tick every TICK_DIV enabled clocks.
// The count holds while en is low and clears on clr.
module sec_tick_gen #(
    parameter int unsigned TICK_DIV = 12048193
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Tick marks the cycle whose closing edge wraps the count back to zero
    assign tick = en && (cnt == CNT_MAX);

    // Prescaler count: clear, hold, or advance with wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_clock_ctrl.sv
// Game clock and shot clock controller: periods, breaks, shot clock,
// buzzer pulses and registered BCD digits for the display drivers.
module game_clock_ctrl
    import scoreboard_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12048193,
    parameter int unsigned Q_LEN    = 60,
    parameter int unsigned REST_LEN = 10,
    parameter int unsigned NUM_Q    = 4,
    parameter int unsigned SHOT_LEN = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             pause_tg,
    input  logic             shot_rst,
    output logic [2:0]       state,
    output logic [2:0]       quarter,
    output logic [NUM_Q-1:0] period_led,
    output logic [3:0]       game_tens,
    output logic [3:0]       game_units,
    output logic [3:0]       shot_tens,
    output logic [3:0]       shot_units,
    output logic             game_buzz,
    output logic             shot_buzz
);

    localparam logic [SEC_W-1:0] Q_SEC    = SEC_W'(Q_LEN);
    localparam logic [SEC_W-1:0] REST_SEC = SEC_W'(REST_LEN);
    localparam logic [SEC_W-1:0] SHOT_SEC = SEC_W'(SHOT_LEN);
    localparam logic [SEC_W-1:0] ONE_SEC  = SEC_W'(1);
    localparam logic [7:0]       GAME_RST_BCD = bin2bcd(Q_SEC);
    localparam logic [7:0]       SHOT_RST_BCD = bin2bcd(SHOT_SEC);

    gc_state_t        st, st_nxt;
    logic [SEC_W-1:0] game_sec, game_nxt;
    logic [SEC_W-1:0] shot_sec, shot_nxt;
    logic [SEC_W-1:0] rest_sec, rest_nxt;
    logic [2:0]       qtr, qtr_nxt;
    logic [NUM_Q-1:0] led, led_nxt;
    logic             game_buzz_nxt, shot_buzz_nxt;
    logic             game_end, shot_end;

    logic             tick, tick_en, tick_clr;

    logic [SEC_W-1:0] game_disp;
    logic [7:0]       game_bcd, shot_bcd;
    logic             shot_blank;

    assign tick_en  = (st == ST_RUN) || (st == ST_BREAK);
    assign tick_clr = (st == ST_IDLE) || (st == ST_FINAL);

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Next-state, count updates and buzzer requests
    always_comb begin
        st_nxt        = st;
        game_nxt      = game_sec;
        shot_nxt      = shot_sec;
        rest_nxt      = rest_sec;
        qtr_nxt       = qtr;
        led_nxt       = led;
        game_buzz_nxt = 1'b0;
        shot_buzz_nxt = 1'b0;
        game_end      = 1'b0;
        shot_end      = 1'b0;

        case (st)
            ST_IDLE: begin
                if (start) begin
                    st_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (tick) begin
                    if (game_sec != '0) begin
                        game_nxt = game_sec - ONE_SEC;
                    end
                    if (shot_sec != '0) begin
                        shot_nxt = shot_sec - ONE_SEC;
                    end
                    game_end = (game_sec == ONE_SEC);
                    // A simultaneous shot_rst reload cancels the violation
                    shot_end = (shot_sec == ONE_SEC) && !shot_rst;
                end

                shot_buzz_nxt = shot_end;

                if (game_end) begin
                    game_buzz_nxt = 1'b1;
                    for (int unsigned i = 0; i < NUM_Q; i++) begin
                        if (qtr == 3'(i)) begin
                            led_nxt[i] = 1'b1;
                        end
                    end
                    st_nxt = (qtr < 3'(NUM_Q - 1)) ? ST_BREAK : ST_FINAL;
                end else if (shot_end || pause_tg) begin
                    st_nxt = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (pause_tg) begin
                    st_nxt = ST_RUN;
                end
            end

            ST_BREAK: begin
                if (tick) begin
                    if (rest_sec <= ONE_SEC) begin
                        qtr_nxt  = qtr + 3'd1;
                        game_nxt = Q_SEC;
                        shot_nxt = SHOT_SEC;
                        rest_nxt = REST_SEC;
                        st_nxt   = ST_PAUSE;
                    end else begin
                        rest_nxt = rest_sec - ONE_SEC;
                    end
                end
            end

            ST_FINAL: begin
                st_nxt = ST_FINAL;
            end

            default: begin
                st_nxt = ST_IDLE;
            end
        endcase

        // Possession change overrides any shot count update this cycle
        if (shot_rst && (st != ST_FINAL)) begin
            shot_nxt = SHOT_SEC;
        end
    end

    // State, count and buzzer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st        <= ST_IDLE;
            game_sec  <= Q_SEC;
            shot_sec  <= SHOT_SEC;
            rest_sec  <= REST_SEC;
            qtr       <= '0;
            led       <= '0;
            game_buzz <= 1'b0;
            shot_buzz <= 1'b0;
        end else begin
            st        <= st_nxt;
            game_sec  <= game_nxt;
            shot_sec  <= shot_nxt;
            rest_sec  <= rest_nxt;
            qtr       <= qtr_nxt;
            led       <= led_nxt;
            game_buzz <= game_buzz_nxt;
            shot_buzz <= shot_buzz_nxt;
        end
    end

    // Display source selection and shot-clock blanking
    always_comb begin
        game_disp  = (st == ST_BREAK) ? rest_sec : game_sec;
        game_bcd   = bin2bcd(game_disp);
        shot_bcd   = bin2bcd(shot_sec);
        shot_blank = (st == ST_BREAK) || (st == ST_FINAL) || (game_sec < shot_sec);
    end

    // Registered BCD digits for the 7-segment drivers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            game_tens  <= GAME_RST_BCD[7:4];
            game_units <= GAME_RST_BCD[3:0];
            shot_tens  <= SHOT_RST_BCD[7:4];
            shot_units <= SHOT_RST_BCD[3:0];
        end else begin
            game_tens  <= game_bcd[7:4];
            game_units <= game_bcd[3:0];
            shot_tens  <= shot_blank ? BLANK : shot_bcd[7:4];
            shot_units <= shot_blank ? BLANK : shot_bcd[3:0];
        end
    end

    assign state      = st;
    assign quarter    = qtr;
    assign period_led = led;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Scoreboard bench for game_clock_ctrl with a short tick divider.
module tb_game_clock_ctrl;
    import scoreboard_pkg::*;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned Q_LEN    = 3;
    localparam int unsigned REST_LEN = 2;
    localparam int unsigned NUM_Q    = 2;
    localparam int unsigned SHOT_LEN = 2;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start, pause_tg, shot_rst;
    logic [2:0]       state, quarter;
    logic [NUM_Q-1:0] period_led;
    logic [3:0]       game_tens, game_units, shot_tens, shot_units;
    logic             game_buzz, shot_buzz;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_seen = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    game_clock_ctrl #(
        .TICK_DIV (TICK_DIV),
        .Q_LEN    (Q_LEN),
        .REST_LEN (REST_LEN),
        .NUM_Q    (NUM_Q),
        .SHOT_LEN (SHOT_LEN)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .pause_tg   (pause_tg),
        .shot_rst   (shot_rst),
        .state      (state),
        .quarter    (quarter),
        .period_led (period_led),
        .game_tens  (game_tens),
        .game_units (game_units),
        .shot_tens  (shot_tens),
        .shot_units (shot_units),
        .game_buzz  (game_buzz),
        .shot_buzz  (shot_buzz)
    );

    // Count seconds ticks mid-cycle
    always @(negedge clk) begin
        if (dut.tick === 1'b1) tick_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            $display("FAIL sb_empty: got observation %0d with no expected entry", obs);
            $fatal(1, "scoreboard underflow");
        end
        it = sb_q.pop_front();
        check_eq(it.tag, obs, it.exp);
    endtask

    // One-cycle pulse launched at a negedge, sampled at the next posedge
    task automatic pulse(input logic s, input logic p, input logic r);
        start    = s;
        pause_tg = p;
        shot_rst = r;
        @(posedge clk);
        #1;
        start    = 1'b0;
        pause_tg = 1'b0;
        shot_rst = 1'b0;
    endtask

    // Negedges until an event: 0 shot_buzz, 1 game_buzz, 2 tick, 3 state==PAUSE
    task automatic wait_ev(input int sel, input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if ((sel == 0 && shot_buzz === 1'b1) ||
                (sel == 1 && game_buzz === 1'b1) ||
                (sel == 2 && dut.tick === 1'b1) ||
                (sel == 3 && state === 3'(ST_PAUSE))) return;
        end
        n = 999;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tk;

        rstn = 1'b0; start = 1'b0; pause_tg = 1'b0; shot_rst = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Idle for 20 cycles, pause_tg ignored, no ticks
        sb_push("idle_state", 32'(ST_IDLE));
        sb_push("idle_game_tens", 0);
        sb_push("idle_game_units", 3);
        sb_push("idle_shot_tens", 0);
        sb_push("idle_shot_units", 2);
        sb_push("idle_ticks", 0);
        sb_push("idle_buzz", 0);
        tk = tick_seen;
        repeat (10) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        sb_pop(32'(state));
        sb_pop(32'(game_tens));
        sb_pop(32'(game_units));
        sb_pop(32'(shot_tens));
        sb_pop(32'(shot_units));
        sb_pop(32'(tick_seen - tk));
        sb_pop(32'({game_buzz, shot_buzz}));

        // Start; shot clock expires on the second tick
        sb_push("shot_viol_latency", 9);
        sb_push("shot_viol_state", 32'(ST_PAUSE));
        sb_push("shot_viol_no_game_buzz", 0);
        sb_push("shot_buzz_width", 0);
        sb_push("viol_game_units", 1);
        sb_push("viol_shot_units", 0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_ev(0, 20, n);
        sb_pop(32'(n));
        sb_pop(32'(state));
        sb_pop(32'(game_buzz));
        @(negedge clk);
        sb_pop(32'(shot_buzz));
        sb_pop(32'(game_units));
        sb_pop(32'(shot_units));

        // shot_rst in PAUSE reloads to 2 > game 1, so shot digits blank
        sb_push("reload_shot_tens", 32'(BLANK));
        sb_push("reload_shot_units", 32'(BLANK));
        sb_push("reload_state", 32'(ST_PAUSE));
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        sb_pop(32'(shot_tens));
        sb_pop(32'(shot_units));
        sb_pop(32'(state));

        // Resume: next tick ends period 0
        sb_push("q0_end_latency", 5);
        sb_push("q0_end_no_shot_buzz", 0);
        sb_push("q0_end_led", 1);
        sb_push("q0_end_state", 32'(ST_BREAK));
        sb_push("game_buzz_width", 0);
        sb_push("break_rest_units_2", 2);
        sb_push("break_shot_blank", 32'(BLANK));
        sb_push("break_rest_units_1", 1);
        sb_push("break_to_pause", 3);
        sb_push("q1_quarter", 1);
        sb_push("q1_game_units", 3);
        sb_push("q1_shot_units", 2);
        sb_push("q1_led", 1);
        pulse(1'b0, 1'b1, 1'b0);
        wait_ev(1, 20, n);
        sb_pop(32'(n));
        sb_pop(32'(shot_buzz));
        sb_pop(32'(period_led));
        sb_pop(32'(state));
        @(negedge clk);
        sb_pop(32'(game_buzz));
        sb_pop(32'(game_units));
        sb_pop(32'(shot_units));
        repeat (4) @(negedge clk);
        sb_pop(32'(game_units));
        wait_ev(3, 20, n);
        sb_pop(32'(n));
        @(negedge clk);
        sb_pop(32'(quarter));
        sb_pop(32'(game_units));
        sb_pop(32'(shot_units));
        sb_pop(32'(period_led));

        // Period 1: pause with the prescaler at 2, hold 10 cycles, resume
        sb_push("midtick_pause_state", 32'(ST_PAUSE));
        sb_push("midtick_pause_ticks", 0);
        sb_push("resume_tick_latency", 2);
        sb_push("after_tick_game_units", 2);
        sb_push("after_tick_shot_units", 1);
        pulse(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        tk = tick_seen;
        repeat (10) @(negedge clk);
        sb_pop(32'(state));
        sb_pop(32'(tick_seen - tk));
        pulse(1'b0, 1'b1, 1'b0);
        wait_ev(2, 20, n);
        sb_pop(32'(n));
        @(negedge clk);
        @(negedge clk);
        sb_pop(32'(game_units));
        sb_pop(32'(shot_units));

        // shot_rst on the tick that would expire the shot clock
        sb_push("rst_on_tick_no_buzz", 0);
        sb_push("rst_on_tick_state", 32'(ST_RUN));
        sb_push("rst_on_tick_game_units", 1);
        sb_push("rst_on_tick_shot_blank", 32'(BLANK));
        @(negedge clk);
        @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        sb_pop(32'(shot_buzz));
        sb_pop(32'(state));
        @(negedge clk);
        sb_pop(32'(game_units));
        sb_pop(32'(shot_units));

        // Last period ends -> FINAL; inputs ignored afterwards
        sb_push("final_latency", 3);
        sb_push("final_state", 32'(ST_FINAL));
        sb_push("final_led", 3);
        sb_push("final_quarter", 1);
        sb_push("final_shot_tens", 32'(BLANK));
        sb_push("final_game_units", 0);
        sb_push("final_hold_state", 32'(ST_FINAL));
        sb_push("final_hold_buzz", 0);
        sb_push("final_hold_ticks", 0);
        wait_ev(1, 20, n);
        sb_pop(32'(n));
        sb_pop(32'(state));
        sb_pop(32'(period_led));
        sb_pop(32'(quarter));
        @(negedge clk);
        sb_pop(32'(shot_tens));
        sb_pop(32'(game_units));
        tk = tick_seen;
        pulse(1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        sb_pop(32'(state));
        sb_pop(32'({game_buzz, shot_buzz}));
        sb_pop(32'(tick_seen - tk));

        // Asynchronous reset between clock edges
        sb_push("areset_state", 32'(ST_IDLE));
        sb_push("areset_quarter", 0);
        sb_push("areset_led", 0);
        sb_push("areset_game_units", 3);
        sb_push("areset_shot_units", 2);
        #2;
        rstn = 1'b0;
        #1;
        sb_pop(32'(state));
        sb_pop(32'(quarter));
        sb_pop(32'(period_led));
        sb_pop(32'(game_units));
        sb_pop(32'(shot_units));
        @(negedge clk);
        rstn = 1'b1;

        // start and pause_tg together in IDLE: start wins
        sb_push("idle_start_prio", 32'(ST_RUN));
        @(negedge clk);
        pulse(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        sb_pop(32'(state));

        check_eq("sb_drain", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
